// File: rtl/dot_product_accumulator_if.sv
// rtl/dot_product_accumulator_if.sv - product input and element output handshakes of the accumulator
interface dot_product_accumulator_if #(
    parameter int WIDTH = 4,
    parameter int IDX_W = 4
);
    logic             prod_valid;
    logic             prod_ready;
    logic [WIDTH-1:0] prod_data;
    logic             sum_valid;
    logic             sum_ready;
    logic [WIDTH-1:0] sum_data;
    logic             sum_ovf;
    logic [IDX_W-1:0] sum_index;
    logic             sum_last;

    modport master (
        output prod_valid, prod_data, sum_ready,
        input  prod_ready, sum_valid, sum_data, sum_ovf, sum_index, sum_last
    );

    modport slave (
        input  prod_valid, prod_data, sum_ready,
        output prod_ready, sum_valid, sum_data, sum_ovf, sum_index, sum_last
    );
endinterface

// File: rtl/dot_product_accumulator.sv
// rtl/dot_product_accumulator.sv - sums every N products into one matrix element with a one-entry output register
module dot_product_accumulator #(
    parameter int WIDTH = 4,
    parameter int N     = 4,
    parameter int IDX_W = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    dot_product_accumulator_if.slave bus
);
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [CNT_W-1:0] LAST_TERM = CNT_W'(N - 1);
    localparam logic [IDX_W-1:0] LAST_ELEM = IDX_W'(N * N - 1);

    logic [WIDTH-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] term_cnt_q, term_cnt_d;
    logic             carry_seen_q, carry_seen_d;
    logic [IDX_W-1:0] elem_idx_q, elem_idx_d;
    logic             sum_valid_q, sum_valid_d;
    logic [WIDTH-1:0] sum_data_q, sum_data_d;
    logic             sum_ovf_q, sum_ovf_d;
    logic [IDX_W-1:0] sum_index_q, sum_index_d;
    logic             sum_last_q, sum_last_d;

    logic             last_term;
    logic             accept;
    logic             drain;
    logic [WIDTH:0]   add_full;

    assign last_term      = (term_cnt_q == LAST_TERM);
    // Only the completing term needs the output register; earlier terms never stall.
    assign bus.prod_ready = !(last_term && sum_valid_q && !bus.sum_ready);
    assign accept         = bus.prod_valid && bus.prod_ready;
    assign drain          = sum_valid_q && bus.sum_ready;
    assign add_full       = {1'b0, acc_q} + {1'b0, bus.prod_data};

    always_comb begin
        acc_d        = acc_q;
        term_cnt_d   = term_cnt_q;
        carry_seen_d = carry_seen_q;
        elem_idx_d   = elem_idx_q;
        sum_valid_d  = sum_valid_q;
        sum_data_d   = sum_data_q;
        sum_ovf_d    = sum_ovf_q;
        sum_index_d  = sum_index_q;
        sum_last_d   = sum_last_q;

        if (drain) begin
            sum_valid_d = 1'b0;
        end

        if (accept) begin
            if (!last_term) begin
                acc_d        = add_full[WIDTH-1:0];
                carry_seen_d = carry_seen_q | add_full[WIDTH];
                term_cnt_d   = term_cnt_q + 1'b1;
            end else begin
                sum_data_d   = add_full[WIDTH-1:0];
                sum_ovf_d    = carry_seen_q | add_full[WIDTH];
                sum_index_d  = elem_idx_q;
                sum_last_d   = (elem_idx_q == LAST_ELEM);
                sum_valid_d  = 1'b1;
                acc_d        = '0;
                term_cnt_d   = '0;
                carry_seen_d = 1'b0;
                elem_idx_d   = (elem_idx_q == LAST_ELEM) ? '0 : elem_idx_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q        <= '0;
            term_cnt_q   <= '0;
            carry_seen_q <= 1'b0;
            elem_idx_q   <= '0;
            sum_valid_q  <= 1'b0;
            sum_data_q   <= '0;
            sum_ovf_q    <= 1'b0;
            sum_index_q  <= '0;
            sum_last_q   <= 1'b0;
        end else begin
            acc_q        <= acc_d;
            term_cnt_q   <= term_cnt_d;
            carry_seen_q <= carry_seen_d;
            elem_idx_q   <= elem_idx_d;
            sum_valid_q  <= sum_valid_d;
            sum_data_q   <= sum_data_d;
            sum_ovf_q    <= sum_ovf_d;
            sum_index_q  <= sum_index_d;
            sum_last_q   <= sum_last_d;
        end
    end

    assign bus.sum_valid = sum_valid_q;
    assign bus.sum_data  = sum_data_q;
    assign bus.sum_ovf   = sum_ovf_q;
    assign bus.sum_index = sum_index_q;
    assign bus.sum_last  = sum_last_q;
endmodule

// File: tb/tb_dot_product_accumulator.sv
// tb/tb_dot_product_accumulator.sv - scoreboard bench for dot_product_accumulator
module tb_dot_product_accumulator;
    localparam int WIDTH = 4;
    localparam int N     = 4;
    localparam int IDX_W = 4;

    typedef struct {
        int data;
        int ovf;
        int idx;
        int last;
    } elem_t;

    logic clk;
    logic rst;
    bit   rand_ready;
    int   n_vec;
    int   n_err;

    elem_t sb_q[$];
    int    m_acc, m_cnt, m_car, m_idx;
    bit    m_full;

    dot_product_accumulator_if #(.WIDTH(WIDTH), .IDX_W(IDX_W)) bus ();

    dot_product_accumulator #(.WIDTH(WIDTH), .N(N), .IDX_W(IDX_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model and scoreboard, evaluated mid-cycle when all signals are settled.
    initial begin
        bit    exp_rdy, drain, complete;
        int    s;
        elem_t e;
        m_acc = 0; m_cnt = 0; m_car = 0; m_idx = 0; m_full = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                m_acc = 0; m_cnt = 0; m_car = 0; m_idx = 0; m_full = 0;
                sb_q.delete();
            end else begin
                exp_rdy = !(m_cnt == N - 1 && m_full && !bus.sum_ready);
                check("prod_ready", 32'(bus.prod_ready), 32'(exp_rdy));
                check("sum_valid", 32'(bus.sum_valid), 32'(m_full));
                drain = m_full && bus.sum_ready;
                if (m_full) begin
                    if (sb_q.size() == 0) begin
                        check("sb_underflow", 32'(sb_q.size()), 32'd1);
                    end else begin
                        check("sum_data", 32'(bus.sum_data), 32'(sb_q[0].data));
                        check("sum_ovf", 32'(bus.sum_ovf), 32'(sb_q[0].ovf));
                        check("sum_index", 32'(bus.sum_index), 32'(sb_q[0].idx));
                        check("sum_last", 32'(bus.sum_last), 32'(sb_q[0].last));
                        if (drain) void'(sb_q.pop_front());
                    end
                end
                complete = 0;
                if (bus.prod_valid && exp_rdy) begin
                    s = m_acc + int'(bus.prod_data);
                    if (s >= (1 << WIDTH)) m_car = 1;
                    m_acc = s % (1 << WIDTH);
                    if (m_cnt == N - 1) begin
                        e.data = m_acc;
                        e.ovf  = m_car;
                        e.idx  = m_idx;
                        e.last = (m_idx == N * N - 1) ? 1 : 0;
                        sb_q.push_back(e);
                        m_idx = (m_idx + 1) % (N * N);
                        m_acc = 0; m_cnt = 0; m_car = 0;
                        complete = 1;
                    end else begin
                        m_cnt++;
                    end
                end
                m_full = (m_full && !drain) || complete;
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rand_ready) bus.sum_ready = 1'($urandom_range(0, 1));
        end
    end

    task automatic send(input int v);
        int  t;
        bit  ok;
        t = 0;
        bus.prod_valid = 1'b1;
        bus.prod_data  = 4'(v);
        forever begin
            @(negedge clk);
            ok = bus.prod_ready;
            @(posedge clk);
            #1;
            if (ok) break;
            t++;
            if (t > 200) begin
                check("send_timeout", 32'(t), 32'd0);
                break;
            end
        end
        bus.prod_valid = 1'b0;
        bus.prod_data  = 4'($urandom_range(0, 15));
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle(2);
        rst = 1'b0;
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        rand_ready     = 0;
        rst            = 1'b1;
        bus.prod_valid = 1'b0;
        bus.prod_data  = '0;
        bus.sum_ready  = 1'b1;
        idle(3);
        rst = 1'b0;
        @(negedge clk);
        check("rst_valid", 32'(bus.sum_valid), 32'd0);
        check("rst_data", 32'(bus.sum_data), 32'd0);
        check("rst_ovf", 32'(bus.sum_ovf), 32'd0);
        check("rst_index", 32'(bus.sum_index), 32'd0);
        check("rst_last", 32'(bus.sum_last), 32'd0);
        @(posedge clk);
        #1;

        // Basic sum, then wrapped sum with carry, then a carry-free element.
        send(1); send(2); send(3); send(4);
        @(negedge clk);
        check("t1_valid", 32'(bus.sum_valid), 32'd1);
        check("t1_data", 32'(bus.sum_data), 32'd10);
        @(posedge clk);
        #1;
        send(15); send(15); send(1); send(0);
        send(0); send(0); send(0); send(1);
        idle(2);

        // Stall the output: the completing term of element 1 must wait.
        bus.sum_ready = 1'b0;
        for (int i = 0; i < 7; i++) send(i + 2);
        bus.prod_valid = 1'b1;
        bus.prod_data  = 4'd9;
        @(negedge clk);
        check("t3_stall", 32'(bus.prod_ready), 32'd0);
        @(posedge clk);
        #1;
        bus.sum_ready = 1'b1;
        send(9);
        idle(3);

        // Full matrix of ones, index wrap, then reset mid-element.
        do_reset();
        for (int i = 0; i < 64; i++) send(1);
        for (int i = 0; i < 22; i++) send(1);
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        @(negedge clk);
        check("t5_valid", 32'(bus.sum_valid), 32'd0);
        check("t5_data", 32'(bus.sum_data), 32'd0);
        check("t5_index", 32'(bus.sum_index), 32'd0);
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) send(2);
        @(negedge clk);
        check("t5_sum", 32'(bus.sum_data), 32'd8);
        check("t5_idx", 32'(bus.sum_index), 32'd0);
        @(posedge clk);
        #1;

        // Random gaps on both sides.
        rand_ready = 1;
        for (int i = 0; i < 1000; i++) begin
            send($urandom_range(0, 15));
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
        end
        rand_ready = 0;
        @(posedge clk);
        #1;
        bus.sum_ready = 1'b1;
        idle(6);
        check("sb_drained", 32'(sb_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
